// File: rtl/sata_align_inserter.sv
// sata_align_inserter: TX ALIGN-burst/SYNC-fill merger and RX ALIGN stripper between link layer and OOB block.
// Rev 1.0
`default_nettype none

module sata_align_inserter #(
  parameter int ALIGN_INTERVAL = 256,
  parameter int ALIGN_BURST    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        linkup,
  input  logic [31:0] ll_tx_data,
  input  logic        ll_tx_charisk,
  input  logic        ll_tx_valid,
  output logic        ll_tx_ready,
  output logic [31:0] tx_dataout,
  output logic        tx_charisk_out,
  input  logic [31:0] rx_datain,
  input  logic [3:0]  rx_charisk,
  output logic [31:0] ll_rx_data,
  output logic        ll_rx_charisk,
  output logic        ll_rx_valid,
  output logic        rx_align_det,
  output logic [1:0]  state_out
);

  localparam logic [31:0] c_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] c_SYNC  = 32'hB5B5957C;

  localparam int c_IW = $clog2(ALIGN_INTERVAL);
  localparam int c_BW = (ALIGN_BURST > 1) ? $clog2(ALIGN_BURST) : 1;
  localparam logic [c_IW-1:0] c_INT_LAST   = c_IW'(ALIGN_INTERVAL - 1);
  localparam logic [c_BW-1:0] c_BURST_LAST = c_BW'(ALIGN_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_PASS  = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_IW-1:0]   r_int_cnt;
  logic [c_BW-1:0]   r_burst_cnt;
  logic [31:0]       r_tx_data;
  logic              r_tx_k;

  logic [31:0]       r_rx_data;
  logic              r_rx_k;
  logic              r_rx_valid;
  logic              r_rx_align;

  logic              w_accept;
  logic              w_is_align;
  logic              w_unused_rx_k;

  assign ll_tx_ready = linkup && (r_state == ST_PASS);
  assign w_accept    = ll_tx_valid && ll_tx_ready;

  // Dropping linkup takes priority over every burst/interval boundary.
  always_ff @(posedge clk) begin
    if (reset || !linkup) begin
      r_state     <= ST_IDLE;
      r_int_cnt   <= '0;
      r_burst_cnt <= '0;
      r_tx_data   <= c_ALIGN;
      r_tx_k      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx_data   <= c_ALIGN;
          r_tx_k      <= 1'b1;
          r_burst_cnt <= '0;
          r_state     <= ST_ALIGN;
        end
        ST_ALIGN: begin
          r_tx_data <= c_ALIGN;
          r_tx_k    <= 1'b1;
          if (r_burst_cnt == c_BURST_LAST) begin
            r_burst_cnt <= '0;
            r_int_cnt   <= '0;
            r_state     <= ST_PASS;
          end else begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end
        ST_PASS: begin
          if (w_accept) begin
            r_tx_data <= ll_tx_data;
            r_tx_k    <= ll_tx_charisk;
          end else begin
            r_tx_data <= c_SYNC;
            r_tx_k    <= 1'b1;
          end
          // Interval counts PASS cycles, not accepted dwords.
          if (r_int_cnt == c_INT_LAST) begin
            r_int_cnt   <= '0;
            r_burst_cnt <= '0;
            r_state     <= ST_ALIGN;
          end else begin
            r_int_cnt <= r_int_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_int_cnt   <= '0;
          r_burst_cnt <= '0;
          r_tx_data   <= c_ALIGN;
          r_tx_k      <= 1'b1;
        end
      endcase
    end
  end

  assign w_is_align    = rx_charisk[0] && (rx_datain == c_ALIGN);
  assign w_unused_rx_k = ^rx_charisk[3:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data  <= '0;
      r_rx_k     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_align <= 1'b0;
    end else begin
      r_rx_data  <= rx_datain;
      r_rx_k     <= rx_charisk[0];
      r_rx_valid <= linkup && !w_is_align;
      r_rx_align <= w_is_align;
    end
  end

  assign tx_dataout     = r_tx_data;
  assign tx_charisk_out = r_tx_k;
  assign ll_rx_data     = r_rx_data;
  assign ll_rx_charisk  = r_rx_k;
  assign ll_rx_valid    = r_rx_valid;
  assign rx_align_det   = r_rx_align;
  assign state_out      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_sata_align_inserter.sv
// tb_sata_align_inserter: randomized scoreboard bench, default (256/2) and small (4/1) instances side by side.
// Rev 1.0
`default_nettype none

module tb_sata_align_inserter;

  localparam logic [31:0] c_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] c_SYNC  = 32'hB5B5957C;
  localparam int c_INT0 = 256;
  localparam int c_BUR0 = 2;
  localparam int c_INT1 = 4;
  localparam int c_BUR1 = 1;

  logic        clk;
  logic        reset;
  logic        linkup;
  logic [31:0] ll_tx_data;
  logic        ll_tx_charisk;
  logic        ll_tx_valid;
  logic [31:0] rx_datain;
  logic [3:0]  rx_charisk;

  logic        rdy0, rdy1;
  logic [31:0] txd0, txd1;
  logic        txk0, txk1;
  logic [31:0] rxd0, rxd1;
  logic        rxk0, rxk1, rxv0, rxv1, rxa0, rxa1;
  logic [1:0]  st0, st1;

  sata_align_inserter u_dut0 (
    .clk(clk), .reset(reset), .linkup(linkup),
    .ll_tx_data(ll_tx_data), .ll_tx_charisk(ll_tx_charisk), .ll_tx_valid(ll_tx_valid),
    .ll_tx_ready(rdy0), .tx_dataout(txd0), .tx_charisk_out(txk0),
    .rx_datain(rx_datain), .rx_charisk(rx_charisk),
    .ll_rx_data(rxd0), .ll_rx_charisk(rxk0), .ll_rx_valid(rxv0),
    .rx_align_det(rxa0), .state_out(st0)
  );

  sata_align_inserter #(.ALIGN_INTERVAL(c_INT1), .ALIGN_BURST(c_BUR1)) u_dut1 (
    .clk(clk), .reset(reset), .linkup(linkup),
    .ll_tx_data(ll_tx_data), .ll_tx_charisk(ll_tx_charisk), .ll_tx_valid(ll_tx_valid),
    .ll_tx_ready(rdy1), .tx_dataout(txd1), .tx_charisk_out(txk1),
    .rx_datain(rx_datain), .rx_charisk(rx_charisk),
    .ll_rx_data(rxd1), .ll_rx_charisk(rxk1), .ll_rx_valid(rxv1),
    .rx_align_det(rxa1), .state_out(st1)
  );

  typedef struct {
    logic [31:0] d0; logic k0;
    logic [31:0] d1; logic k1;
    logic [31:0] rd; logic rk; logic rv; logic ra;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   pops   = 0;
  int   s0 = 0;
  int   s1 = 0;
  bit   armed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // s = linkup-high cycles since the last IDLE entry; 0 = IDLE, then a repeating
  // pattern of BURST align cycles followed by INTERVAL pass cycles.
  function automatic int phase(input int s, input int burst, input int interval);
    if (s == 0) return 0;
    return (((s - 1) % (burst + interval)) < burst) ? 1 : 2;
  endfunction

  task automatic model_tx(input int s, input int burst, input int interval,
                          output logic [31:0] d, output logic k);
    if (reset || !linkup || phase(s, burst, interval) != 2) begin
      d = c_ALIGN; k = 1'b1;
    end else if (ll_tx_valid) begin
      d = ll_tx_data; k = ll_tx_charisk;
    end else begin
      d = c_SYNC; k = 1'b1;
    end
  endtask

  task automatic step();
    exp_t e;
    bit   is_align;
    #1;
    if (armed) begin
      check("ready0", {31'b0, rdy0}, {31'b0, linkup && phase(s0, c_BUR0, c_INT0) == 2});
      check("state0", {30'b0, st0}, phase(s0, c_BUR0, c_INT0));
      check("ready1", {31'b0, rdy1}, {31'b0, linkup && phase(s1, c_BUR1, c_INT1) == 2});
      check("state1", {30'b0, st1}, phase(s1, c_BUR1, c_INT1));
    end
    model_tx(s0, c_BUR0, c_INT0, e.d0, e.k0);
    model_tx(s1, c_BUR1, c_INT1, e.d1, e.k1);
    is_align = rx_charisk[0] && (rx_datain == c_ALIGN);
    if (reset) begin
      e.rd = '0; e.rk = 1'b0; e.rv = 1'b0; e.ra = 1'b0;
    end else begin
      e.rd = rx_datain; e.rk = rx_charisk[0]; e.rv = linkup && !is_align; e.ra = is_align;
    end
    exp_q.push_back(e);
    pushes++;
    s0 = (reset || !linkup) ? 0 : s0 + 1;
    s1 = (reset || !linkup) ? 0 : s1 + 1;
    if (reset) armed = 1;
    @(negedge clk);
  endtask

  task automatic rand_in(input int valid_pct);
    ll_tx_data    = $urandom;
    ll_tx_charisk = 1'($urandom_range(0, 1));
    ll_tx_valid   = ($urandom_range(0, 99) < valid_pct);
    rx_datain     = ($urandom_range(0, 3) == 0) ? c_ALIGN : $urandom;
    rx_charisk    = 4'($urandom_range(0, 15));
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pops++;
      check("txd0", txd0, e.d0);
      check("txk0", {31'b0, txk0}, {31'b0, e.k0});
      check("txd1", txd1, e.d1);
      check("txk1", {31'b0, txk1}, {31'b0, e.k1});
      check("rxd0", rxd0, e.rd);
      check("rxd1", rxd1, e.rd);
      check("rxk", {30'b0, rxk1, rxk0}, {30'b0, e.rk, e.rk});
      check("rxv", {30'b0, rxv1, rxv0}, {30'b0, e.rv, e.rv});
      check("rxa", {30'b0, rxa1, rxa0}, {30'b0, e.ra, e.ra});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1; linkup = 1'b0;
    rand_in(0);
    repeat (3) begin rand_in(0); step(); end
    reset = 1'b0;
    repeat (2) begin rand_in(0); step(); end
    linkup = 1'b1;
    repeat (600) begin rand_in(100); step(); end
    repeat (300) begin rand_in(0); step(); end
    repeat (150) begin rand_in(60); step(); end
    linkup = 1'b0;
    repeat (3) begin rand_in(100); step(); end
    linkup = 1'b1;
    repeat (20) begin rand_in(100); step(); end
    rx_datain = 32'h12345678; rx_charisk = 4'b0000; step();
    rx_datain = c_ALIGN;      rx_charisk = 4'b0001; step();
    rx_datain = c_ALIGN;      rx_charisk = 4'b1110; step();
    rx_datain = c_SYNC;       rx_charisk = 4'b0001; step();
    repeat (1200) begin
      rand_in(70);
      linkup = ($urandom_range(0, 79) != 0);
      reset  = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; linkup = 1'b0;
    repeat (3) begin rand_in(0); step(); end
    @(posedge clk);
    #3;
    check("drain", 32'(pops), 32'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
